// File: rtl/bmc_pwr_pkg.sv
// ---------------------------------------------------------------------------
// bmc_pwr_pkg
// Shared definitions for the BMC power sequencers: the state encoding of the
// power-down sequencer (also driven out on its debug port) and the default
// millisecond constants.
// ---------------------------------------------------------------------------
package bmc_pwr_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_ARMED      = 3'd1,
        ST_ASSERT_RST = 3'd2,
        ST_VR_OFF     = 3'd3,
        ST_DONE       = 3'd4,
        ST_FLT        = 3'd5
    } pwr_state_e;

    localparam int RST_HOLD_MS_DEF       = 3;
    localparam int VR_OFF_TIMEOUT_MS_DEF = 20;
    localparam int CNT_BITS_DEF          = 5;

    // Shutdown is committed from ASSERT_RST onwards: SRST# stays asserted.
    function automatic logic holds_rst(input pwr_state_e s);
        return (s == ST_ASSERT_RST) || (s == ST_VR_OFF) ||
               (s == ST_DONE)       || (s == ST_FLT);
    endfunction

    // The P2V5 VR enable is forced off from VR_OFF onwards.
    function automatic logic forces_vr_off(input pwr_state_e s);
        return (s == ST_VR_OFF) || (s == ST_DONE) || (s == ST_FLT);
    endfunction

endpackage

// File: rtl/bmc_ms_timer.sv
// ---------------------------------------------------------------------------
// bmc_ms_timer
// Millisecond timer: counts 1 ms enables, clears on request, saturates at
// all-ones and flags when the count is at or above a supplied limit.
//
// Ports:
//   iClk, iRst  clock, synchronous active-high reset
//   iClr        clear the count (wins over iTick)
//   iTick       1 ms enable, one iClk cycle wide
//   iLimit      threshold for oReached
//   oReached    count >= iLimit (from the registered count)
// ---------------------------------------------------------------------------
module bmc_ms_timer #(
    parameter int CNT_BITS = 5
) (
    input  logic                iClk,
    input  logic                iRst,
    input  logic                iClr,
    input  logic                iTick,
    input  logic [CNT_BITS-1:0] iLimit,
    output logic                oReached
);

    logic [CNT_BITS-1:0] cnt_q;
    logic [CNT_BITS-1:0] cnt_d;

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        cnt_d = cnt_q;
        if (iClr) begin
            cnt_d = '0;
        end else if (iTick && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments only,
    // so every flop samples the pre-edge values regardless of block order.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign oReached = (cnt_q >= iLimit);

endmodule

// File: rtl/bmc_pwrdn_seq.sv
// ---------------------------------------------------------------------------
// bmc_pwrdn_seq
// BMC power-down sequencer. Once the BMC rail is good it waits for a shutdown
// trigger (SLP_SUS# low, up-sequencer fault, forced off), then asserts SRST#,
// holds it for RST_HOLD_MS ticks, forces the P2V5 VR enable off and checks
// that P1V1 PWRGD falls within VR_OFF_TIMEOUT_MS ticks.
//
// Ports:
//   iClk, iRst          clock, synchronous active-high reset
//   i1mSCE              1 ms clock enable, one iClk cycle wide
//   FM_SLP_SUS_N        async board signal, low = shutdown request
//   PWRGD_P1V1_BMC_AUX  async BMC P1V1 power-good
//   iBmcPwrgd           up-sequencer "all BMC VRs good"
//   iBmcPwrFlt          up-sequencer fault flag
//   iForceOff           synchronous forced shutdown
//   iGoOutFltSt         leave the fault state (only honoured in FLT)
//   oSrstReq_n          low = hold the BMC in reset
//   oVrOffReq           high = force FM_BMC_P2V5_AUX_EN low
//   oPwrDnDone          shutdown completed cleanly
//   oPwrDnFlt           VR did not discharge within the timeout
//   oState              current state code (debug)
// ---------------------------------------------------------------------------
module bmc_pwrdn_seq
    import bmc_pwr_pkg::*;
#(
    parameter int RST_HOLD_MS       = RST_HOLD_MS_DEF,
    parameter int VR_OFF_TIMEOUT_MS = VR_OFF_TIMEOUT_MS_DEF,
    parameter int CNT_BITS          = CNT_BITS_DEF
) (
    input  logic       iClk,
    input  logic       iRst,
    input  logic       i1mSCE,
    input  logic       FM_SLP_SUS_N,
    input  logic       PWRGD_P1V1_BMC_AUX,
    input  logic       iBmcPwrgd,
    input  logic       iBmcPwrFlt,
    input  logic       iForceOff,
    input  logic       iGoOutFltSt,
    output logic       oSrstReq_n,
    output logic       oVrOffReq,
    output logic       oPwrDnDone,
    output logic       oPwrDnFlt,
    output logic [2:0] oState
);

    // Two-flop synchronizers for the asynchronous board inputs. They reset to
    // the inactive levels (SLP_SUS# deasserted, PWRGD low) so a reset never
    // looks like a fresh shutdown request.
    logic slp_meta_q, slp_sync_q;
    logic pg_meta_q,  pg_sync_q;

    always_ff @(posedge iClk) begin
        if (iRst) begin
            slp_meta_q <= 1'b1;
            slp_sync_q <= 1'b1;
            pg_meta_q  <= 1'b0;
            pg_sync_q  <= 1'b0;
        end else begin
            slp_meta_q <= FM_SLP_SUS_N;
            slp_sync_q <= slp_meta_q;
            pg_meta_q  <= PWRGD_P1V1_BMC_AUX;
            pg_sync_q  <= pg_meta_q;
        end
    end

    pwr_state_e          state_q, state_d;
    logic                srst_n_q, vr_off_q, done_q, flt_q;
    logic                tmr_clr, tmr_reached;
    logic [CNT_BITS-1:0] tmr_limit;
    logic                trigger;

    assign trigger = !slp_sync_q || iForceOff || iBmcPwrFlt;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (iBmcPwrgd) state_d = ST_ARMED;
            end
            ST_ARMED: begin
                if (trigger)         state_d = ST_ASSERT_RST;
                else if (!iBmcPwrgd) state_d = ST_IDLE;
            end
            ST_ASSERT_RST: begin
                // Committed: a trigger going away does not abort the sequence.
                if (tmr_reached) state_d = ST_VR_OFF;
            end
            ST_VR_OFF: begin
                // A discharged rail wins over a timeout seen on the same cycle.
                if (!pg_sync_q)       state_d = ST_DONE;
                else if (tmr_reached) state_d = ST_FLT;
            end
            ST_DONE: begin
                if (slp_sync_q && !iForceOff) state_d = ST_IDLE;
            end
            ST_FLT: begin
                if (iGoOutFltSt) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // The timer restarts on every state change so each timed state counts
    // only the ticks seen after its entry edge.
    assign tmr_clr   = (state_d != state_q);
    assign tmr_limit = (state_q == ST_ASSERT_RST) ? CNT_BITS'(RST_HOLD_MS)
                                                  : CNT_BITS'(VR_OFF_TIMEOUT_MS);

    bmc_ms_timer #(
        .CNT_BITS (CNT_BITS)
    ) u_timer (
        .iClk     (iClk),
        .iRst     (iRst),
        .iClr     (tmr_clr),
        .iTick    (i1mSCE),
        .iLimit   (tmr_limit),
        .oReached (tmr_reached)
    );

    // Outputs are decoded from the next state so they switch on the same edge
    // as the state register.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q  <= ST_IDLE;
            srst_n_q <= 1'b1;
            vr_off_q <= 1'b0;
            done_q   <= 1'b0;
            flt_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            srst_n_q <= !holds_rst(state_d);
            vr_off_q <= forces_vr_off(state_d);
            done_q   <= (state_d == ST_DONE);
            flt_q    <= (state_d == ST_FLT);
        end
    end

    assign oSrstReq_n = srst_n_q;
    assign oVrOffReq  = vr_off_q;
    assign oPwrDnDone = done_q;
    assign oPwrDnFlt  = flt_q;
    assign oState     = state_q;

endmodule

// File: tb/tb_bmc_pwrdn_seq.sv
// ---------------------------------------------------------------------------
// tb_bmc_pwrdn_seq
// Scoreboard bench for bmc_pwrdn_seq. Stimulus pushes the expected output
// vector {oSrstReq_n, oVrOffReq, oPwrDnDone, oPwrDnFlt, oState} together with
// the clock edge at which it must be visible; a monitor on the falling edge
// pops and compares every entry that has come due.
// ---------------------------------------------------------------------------
module tb_bmc_pwrdn_seq;

    // Expected vectors, built from the output table of each state.
    localparam logic [6:0] E_IDLE   = {4'b1000, 3'd0};
    localparam logic [6:0] E_ARMED  = {4'b1000, 3'd1};
    localparam logic [6:0] E_ASSERT = {4'b0000, 3'd2};
    localparam logic [6:0] E_VROFF  = {4'b0100, 3'd3};
    localparam logic [6:0] E_DONE   = {4'b0110, 3'd4};
    localparam logic [6:0] E_FLT    = {4'b0101, 3'd5};

    logic       iClk = 1'b0;
    logic       iRst;
    logic       i1mSCE;
    logic       FM_SLP_SUS_N;
    logic       PWRGD_P1V1_BMC_AUX;
    logic       iBmcPwrgd;
    logic       iBmcPwrFlt;
    logic       iForceOff;
    logic       iGoOutFltSt;
    logic       oSrstReq_n;
    logic       oVrOffReq;
    logic       oPwrDnDone;
    logic       oPwrDnFlt;
    logic [2:0] oState;

    bmc_pwrdn_seq dut (
        .iClk               (iClk),
        .iRst               (iRst),
        .i1mSCE             (i1mSCE),
        .FM_SLP_SUS_N       (FM_SLP_SUS_N),
        .PWRGD_P1V1_BMC_AUX (PWRGD_P1V1_BMC_AUX),
        .iBmcPwrgd          (iBmcPwrgd),
        .iBmcPwrFlt         (iBmcPwrFlt),
        .iForceOff          (iForceOff),
        .iGoOutFltSt        (iGoOutFltSt),
        .oSrstReq_n         (oSrstReq_n),
        .oVrOffReq          (oVrOffReq),
        .oPwrDnDone         (oPwrDnDone),
        .oPwrDnFlt          (oPwrDnFlt),
        .oState             (oState)
    );

    always #5 iClk = ~iClk;

    int cyc = 0;
    always @(posedge iClk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [6:0] act, input logic [6:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %b want %b", tag, cyc, act, exp);
        end
    endtask

    // Scoreboard queues (one entry per expectation, in due-cycle order).
    int         due_q[$];
    logic [6:0] exp_q[$];
    string      tag_q[$];

    task automatic expect_at(input string tag, input int d, input logic [6:0] exp);
        due_q.push_back(cyc + d);
        exp_q.push_back(exp);
        tag_q.push_back(tag);
    endtask

    always @(negedge iClk) begin
        while (due_q.size() > 0 && due_q[0] <= cyc) begin
            void'(due_q.pop_front());
            chk(tag_q.pop_front(),
                {oSrstReq_n, oVrOffReq, oPwrDnDone, oPwrDnFlt, oState},
                exp_q.pop_front());
        end
    end

    // Advance n rising edges, then settle 1 ns past the edge before driving.
    task automatic step(input int n);
        repeat (n) @(posedge iClk);
        #1;
    endtask

    // One 1 ms enable pulse; it is counted on the edge that ends this call.
    task automatic tick();
        i1mSCE = 1'b1;
        step(1);
        i1mSCE = 1'b0;
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            tick();
            step(1);
        end
    endtask

    initial begin
        iRst               = 1'b1;
        i1mSCE             = 1'b0;
        FM_SLP_SUS_N       = 1'b1;
        PWRGD_P1V1_BMC_AUX = 1'b1;
        iBmcPwrgd          = 1'b0;
        iBmcPwrFlt         = 1'b0;
        iForceOff          = 1'b0;
        iGoOutFltSt        = 1'b0;
        step(3);
        iRst = 1'b0;
        expect_at("reset", 0, E_IDLE);
        step(2);

        // ---- Nominal shutdown via SLP_SUS# ----
        iBmcPwrgd = 1'b1;
        expect_at("nom_armed", 1, E_ARMED);
        step(2);
        FM_SLP_SUS_N = 1'b0;
        expect_at("nom_slp_not_early", 2, E_ARMED);
        expect_at("nom_srst_at_3", 3, E_ASSERT);
        step(3);
        ticks(2);
        tick();
        expect_at("nom_hold_3rd_tick", 0, E_ASSERT);
        expect_at("nom_vr_off", 1, E_VROFF);
        step(2);
        ticks(5);
        PWRGD_P1V1_BMC_AUX = 1'b0;
        expect_at("nom_pg_not_early", 2, E_VROFF);
        expect_at("nom_done_at_3", 3, E_DONE);
        step(3);
        FM_SLP_SUS_N = 1'b1;
        iBmcPwrgd    = 1'b0;
        expect_at("nom_done_hold", 2, E_DONE);
        expect_at("nom_idle", 3, E_IDLE);
        expect_at("nom_idle_stay", 5, E_IDLE);
        step(6);
        PWRGD_P1V1_BMC_AUX = 1'b1;
        step(3);

        // ---- VR stuck, forced-off trigger ----
        iBmcPwrgd = 1'b1;
        expect_at("stk_armed", 1, E_ARMED);
        step(2);
        iForceOff = 1'b1;
        expect_at("stk_force_1edge", 1, E_ASSERT);
        step(1);
        iForceOff = 1'b0;
        ticks(2);
        tick();
        expect_at("stk_vr_off", 1, E_VROFF);
        step(2);
        ticks(19);
        expect_at("stk_19_ticks", 0, E_VROFF);
        tick();
        expect_at("stk_20th_tick", 0, E_VROFF);
        expect_at("stk_flt", 1, E_FLT);
        step(6);
        expect_at("stk_flt_sticky", 0, E_FLT);
        iGoOutFltSt = 1'b1;
        expect_at("stk_flt_exit", 1, E_IDLE);
        expect_at("stk_rearm", 2, E_ARMED);
        step(1);
        iGoOutFltSt = 1'b0;
        step(3);

        // ---- Abort attempt: SLP_SUS# returns high during ASSERT_RST ----
        FM_SLP_SUS_N = 1'b0;
        expect_at("abt_srst", 3, E_ASSERT);
        step(3);
        tick();
        FM_SLP_SUS_N = 1'b1;
        expect_at("abt_no_abort", 4, E_ASSERT);
        step(2);
        tick();
        step(1);
        tick();
        expect_at("abt_hold_3rd_tick", 0, E_ASSERT);
        expect_at("abt_vr_off", 1, E_VROFF);
        step(2);
        PWRGD_P1V1_BMC_AUX = 1'b0;
        expect_at("abt_done", 3, E_DONE);
        expect_at("abt_done_exit", 4, E_IDLE);
        expect_at("abt_rearm", 5, E_ARMED);
        step(6);
        PWRGD_P1V1_BMC_AUX = 1'b1;
        step(3);

        // ---- Go-out ignored outside FLT; fault trigger; reset in VR_OFF ----
        iGoOutFltSt = 1'b1;
        expect_at("goout_ignored", 1, E_ARMED);
        step(1);
        iGoOutFltSt = 1'b0;
        iBmcPwrFlt  = 1'b1;
        expect_at("flt_trig_1edge", 1, E_ASSERT);
        step(1);
        iBmcPwrFlt = 1'b0;
        ticks(2);
        tick();
        expect_at("rst_vr_off", 1, E_VROFF);
        step(3);
        iRst = 1'b1;
        expect_at("rst_mid_seq", 1, E_IDLE);
        step(1);
        iRst = 1'b0;
        expect_at("rst_rearm", 1, E_ARMED);
        step(3);

        // ---- One-cycle SLP_SUS# glitch that passes the synchronizer does
        //      trigger; then PWRGD falls together with the 20th tick ----
        FM_SLP_SUS_N = 1'b0;
        step(1);
        FM_SLP_SUS_N = 1'b1;
        expect_at("glitch_sync", 1, E_ARMED);
        expect_at("glitch_trig", 2, E_ASSERT);
        step(2);
        ticks(2);
        tick();
        expect_at("bnd_vr_off", 1, E_VROFF);
        step(2);
        ticks(19);
        PWRGD_P1V1_BMC_AUX = 1'b0;
        step(1);
        tick();
        expect_at("bnd_20th_tick", 0, E_VROFF);
        expect_at("bnd_done_wins", 1, E_DONE);
        expect_at("bnd_idle", 2, E_IDLE);
        expect_at("bnd_rearm", 3, E_ARMED);
        step(5);
        PWRGD_P1V1_BMC_AUX = 1'b1;
        iBmcPwrgd          = 1'b0;
        expect_at("end_idle", 2, E_IDLE);
        step(5);

        if (due_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d expectations never compared, want 0", due_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
